mdio_master: RTL and testbench

Clause-22 MDIO management initiator for the Ti180 GMII repeater. It takes the MDC/MDIOI/MDIOO/MDIOE pins of one PHY port, which are currently tied off at the top level. A single-command register interface issues 64-bit read and write frames to the PHY, which acts as responder. The block returns read data with a turnaround-error flag. One instance per PHY port, clocked from that port's TCLK (125 MHz).

---
 rtl/mdio_pkg.sv | 43 ++++
 rtl/mdio_clkgen.sv | 44 ++++
 rtl/mdio_master.sv | 175 +++++++++++++++++
 tb/tb_mdio_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO frame constants, FSM state type and frame builder for the Clause-22 initiator.
package mdio_pkg;

    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;

    localparam int PRE_LEN = 32;
    localparam int HDR_LEN = 14;
    localparam int TA_LEN  = 2;
    localparam int DAT_LEN = 16;

    // Last frame position (0..63) of each field, counted from the first preamble bit.
    localparam logic [5:0] POS_PRE_END = 6'(PRE_LEN - 1);
    localparam logic [5:0] POS_HDR_END = 6'(PRE_LEN + HDR_LEN - 1);
    localparam logic [5:0] POS_TA_END  = 6'(PRE_LEN + HDR_LEN + TA_LEN - 1);
    localparam logic [5:0] POS_DAT_END = 6'(PRE_LEN + HDR_LEN + TA_LEN + DAT_LEN - 1);
    localparam logic [5:0] POS_SKIP    = 6'(PRE_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    // Reads leave TA/DATA at zero; those bits are never driven on the pin.
    function automatic logic [63:0] build_frame(input logic        wr,
                                                input logic [4:0]  phyad,
                                                input logic [4:0]  regad,
                                                input logic [15:0] wdat);
        logic [1:0]  op;
        logic [1:0]  ta;
        logic [15:0] dat;
        op  = wr ? OP_WR : OP_RD;
        ta  = wr ? 2'b10 : 2'b00;
        dat = wr ? wdat  : 16'h0000;
        build_frame = {{PRE_LEN{1'b1}}, ST_CODE, op, phyad, regad, ta, dat};
    endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator: DIV-cycle half-period counter, MDC register and one-cycle rise/fall strobes.
// Strobes are asserted in the cycle before the edge on which MDC toggles; disabled means MDC low.
module mdio_clkgen
    import mdio_pkg::*;
#(
    parameter int DIV = 25
) (
    input  logic i_tclk,
    input  logic i_arstn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_mdc,
    output logic o_mdc_rise,
    output logic o_mdc_fall
);

    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_mdc;
    logic          w_wrap;

    assign w_wrap     = i_en && (r_cnt == CNT_MAX);
    assign o_mdc_rise = w_wrap && !r_mdc;
    assign o_mdc_fall = w_wrap &&  r_mdc;
    assign o_mdc      = r_mdc;

    always_ff @(posedge i_tclk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_mdc <= ~r_mdc;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO initiator: one command per 64-bit frame, RSP_VALID pulse 128*DIV+1 cycles after accept.
// Build macro MDIO_PREAMBLE_SUPPRESS_EN: frames after the first since reset omit the 32-bit preamble.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int DIV = 25
) (
    input  logic        i_tclk,
    input  logic        i_arstn,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_wr,
    input  logic [4:0]  i_cmd_phyad,
    input  logic [4:0]  i_cmd_regad,
    input  logic [15:0] i_cmd_wdat,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdat,
    output logic        o_rsp_err,
    output logic        o_mdc,
    input  logic        i_mdioi,
    output logic        o_mdioo,
    output logic        o_mdioe
);

    state_t      r_state, w_next;
    logic        w_accept, w_clk_en, w_rise, w_fall, w_skip, w_short, w_sync;
    logic        r_sync1, r_sync2, r_wr, r_ta_err, r_mdioe;
    logic        r_rsp_valid, r_rsp_err;
    logic [5:0]  r_bit_cnt, w_pos;
    logic [63:0] r_shift, w_frame;
    logic [15:0] r_rdat, r_rsp_rdat;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic r_pre_sent, r_short;

    always_ff @(posedge i_tclk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_pre_sent <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            if (r_state == S_DONE)
                r_pre_sent <= 1'b1;
            if (w_accept)
                r_short <= r_pre_sent;
        end
    end

    assign w_skip  = r_pre_sent;
    assign w_short = r_short;
`else
    assign w_skip  = 1'b0;
    assign w_short = 1'b0;
`endif

    // Short frames start at the header, so the transmitted-bit counter is offset into frame positions.
    assign w_pos   = r_bit_cnt + (w_short ? POS_SKIP : 6'd0);
    assign w_frame = build_frame(i_cmd_wr, i_cmd_phyad, i_cmd_regad, i_cmd_wdat);
    assign w_sync  = r_sync2;

    mdio_clkgen #(
        .DIV (DIV)
    ) u_clkgen (
        .i_tclk     (i_tclk),
        .i_arstn    (i_arstn),
        .i_en       (w_clk_en),
        .i_clr      (w_accept),
        .o_mdc      (o_mdc),
        .o_mdc_rise (w_rise),
        .o_mdc_fall (w_fall)
    );

    always_ff @(posedge i_tclk or negedge i_arstn) begin
        if (!i_arstn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_cmd_ready = 1'b0;
        w_accept    = 1'b0;
        w_clk_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_skip ? S_HDR : S_PRE;
                end
            end
            S_PRE: begin
                w_clk_en = 1'b1;
                if (w_fall && w_pos == POS_PRE_END)
                    w_next = S_HDR;
            end
            S_HDR: begin
                w_clk_en = 1'b1;
                if (w_fall && w_pos == POS_HDR_END)
                    w_next = S_TA;
            end
            S_TA: begin
                w_clk_en = 1'b1;
                if (w_fall && w_pos == POS_TA_END)
                    w_next = S_DATA;
            end
            S_DATA: begin
                w_clk_en = 1'b1;
                if (w_fall && w_pos == POS_DAT_END)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_tclk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_mdioi;
            r_sync2 <= r_sync1;
        end
    end

    // MDIOO is the MSB of the shift register; the zero fill leaves the pin low once the frame is out.
    always_ff @(posedge i_tclk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_wr        <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_mdioe     <= 1'b0;
            r_ta_err    <= 1'b0;
            r_rdat      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdat  <= '0;
        end else begin
            r_rsp_valid <= (r_state == S_DONE);
            if (w_accept) begin
                r_wr      <= i_cmd_wr;
                r_bit_cnt <= '0;
                r_shift   <= w_skip ? {w_frame[31:0], 32'h0} : w_frame;
                r_mdioe   <= 1'b1;
                r_ta_err  <= 1'b0;
            end
            if (w_fall) begin
                r_shift <= {r_shift[62:0], 1'b0};
                if (w_pos != POS_DAT_END)
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                if (w_pos == POS_DAT_END || (!r_wr && w_pos == POS_HDR_END))
                    r_mdioe <= 1'b0;
            end
            if (w_rise && !r_wr) begin
                if (r_state == S_TA && w_pos == POS_TA_END)
                    r_ta_err <= w_sync;
                if (r_state == S_DATA)
                    r_rdat <= {r_rdat[14:0], w_sync};
            end
            if (r_state == S_DONE) begin
                r_rsp_err <= ~r_wr & r_ta_err;
                if (!r_wr)
                    r_rsp_rdat <= r_rdat;
            end
        end
    end

    assign o_mdioo     = r_shift[63];
    assign o_mdioe     = r_mdioe;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdat  = r_rsp_rdat;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master at DIV=4: frame bits, MDC waveform, handshake, read responder, reset abort.
module tb_mdio_master;

    localparam int DIV = 4;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam bit SUPP = 1'b1;
`else
    localparam bit SUPP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arstn;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [4:0]  cmd_phyad, cmd_regad;
    logic [15:0] cmd_wdat;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdat;
    logic        mdc, mdioi, mdioo, mdioe;

    always #5 clk = ~clk;

    mdio_master #(.DIV(DIV)) dut (
        .i_tclk      (clk),
        .i_arstn     (arstn),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_wr    (cmd_wr),
        .i_cmd_phyad (cmd_phyad),
        .i_cmd_regad (cmd_regad),
        .i_cmd_wdat  (cmd_wdat),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdat  (rsp_rdat),
        .o_rsp_err   (rsp_err),
        .o_mdc       (mdc),
        .i_mdioi     (mdioi),
        .o_mdioo     (mdioo),
        .o_mdioe     (mdioe)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit pre_armed;

    typedef struct {
        logic [63:0] obits;
        logic [63:0] ebits;
        int          vld_at;
        int          n_vld;
        int          mdc_bad;
        int          rdy_bad;
        int          stab_bad;
        int          wait_n;
        logic [15:0] rdat;
        logic        err;
    } res_t;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the RSP_VALID cycle (rel = 2*nbits*DIV+1).
    task automatic run_frame(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, input bit phy, input logic [15:0] pd,
                             input bit hold, output res_t r);
        int nbits, lim, p, idx;
        nbits      = (SUPP && !pre_armed) ? 32 : 64;
        lim        = 2 * nbits * DIV + 1;
        r.obits    = '0;
        r.ebits    = '0;
        r.vld_at   = -1;
        r.n_vld    = 0;
        r.mdc_bad  = 0;
        r.rdy_bad  = 0;
        r.stab_bad = 0;
        r.wait_n   = 0;
        r.rdat     = '0;
        r.err      = 1'b0;
        cmd_wr    = wr;
        cmd_phyad = pa;
        cmd_regad = ra;
        cmd_wdat  = wd;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && r.wait_n < 100) begin
            @(negedge clk);
            r.wait_n++;
        end
        if (r.wait_n >= 100)
            check_eq("accept_timeout", 64'(r.wait_n), 64'd0);
        @(posedge clk);
        #1;
        if (!hold)
            cmd_valid = 1'b0;
        for (int rel = 0; rel <= lim; rel++) begin
            @(negedge clk);
            idx = nbits - 1 - rel / (2 * DIV);
            if (rel < 2 * nbits * DIV) begin
                if (mdc !== (((rel / DIV) % 2) == 1))
                    r.mdc_bad++;
                if (rel % (2 * DIV) == 1) begin
                    r.obits[idx] = mdioo;
                    r.ebits[idx] = mdioe;
                end
                if (rel % (2 * DIV) == 2 * DIV - 1 &&
                    (mdioo !== r.obits[idx] || mdioe !== r.ebits[idx]))
                    r.stab_bad++;
            end else if (mdc !== 1'b0) begin
                r.mdc_bad++;
            end
            if (rel < lim && cmd_ready !== 1'b0)
                r.rdy_bad++;
            if (rel == lim && cmd_ready !== 1'b1)
                r.rdy_bad++;
            if (rsp_valid === 1'b1) begin
                r.n_vld++;
                if (r.vld_at < 0) begin
                    r.vld_at = rel;
                    r.rdat   = rsp_rdat;
                    r.err    = rsp_err;
                end
            end
            p     = rel / (2 * DIV) + 64 - nbits;
            mdioi = 1'b1;
            if (phy && p == 47)
                mdioi = 1'b0;
            else if (phy && p >= 48 && p <= 63)
                mdioi = pd[63 - p];
        end
        mdioi = 1'b1;
        if (r.vld_at >= 0)
            pre_armed = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   nv;
        arstn     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_phyad = '0;
        cmd_regad = '0;
        cmd_wdat  = '0;
        mdioi     = 1'b1;
        pre_armed = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("rst_mdc",       64'(mdc),       64'd0);
        check_eq("rst_mdioo",     64'(mdioo),     64'd0);
        check_eq("rst_mdioe",     64'(mdioe),     64'd0);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_rdat",  64'(rsp_rdat),  64'd0);
        check_eq("rst_rsp_err",   64'(rsp_err),   64'd0);
        arstn = 1'b1;
        @(negedge clk);

        // Write PHYAD=1 REGAD=0 WDAT=1140: always a full frame.
        run_frame(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0, 1'b0, r);
        check_eq("wr_bits",   r.obits,            64'hFFFF_FFFF_5082_1140);
        check_eq("wr_oe",     r.ebits,            64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("wr_vld_at", 64'(r.vld_at),      64'd513);
        check_eq("wr_n_vld",  64'(r.n_vld),       64'd1);
        check_eq("wr_err",    64'(r.err),         64'd0);
        check_eq("wr_rdat",   64'(r.rdat),        64'h0000);
        check_eq("wr_mdc",    64'(r.mdc_bad),     64'd0);
        check_eq("wr_ready",  64'(r.rdy_bad),     64'd0);
        check_eq("wr_stable", 64'(r.stab_bad),    64'd0);

        // Read PHYAD=1 REGAD=1 from a responding PHY.
        run_frame(1'b0, 5'd1, 5'd1, 16'h0, 1'b1, 16'h796D, 1'b0, r);
        check_eq("rd_bits",   r.obits & (SUPP ? 64'h0000_0000_FFFC_0000 : 64'hFFFF_FFFF_FFFC_0000),
                              SUPP ? 64'h0000_0000_6084_0000 : 64'hFFFF_FFFF_6084_0000);
        check_eq("rd_oe",     r.ebits, SUPP ? 64'h0000_0000_FFFC_0000 : 64'hFFFF_FFFF_FFFC_0000);
        check_eq("rd_rdat",   64'(r.rdat),    64'h796D);
        check_eq("rd_err",    64'(r.err),     64'd0);
        check_eq("rd_vld_at", 64'(r.vld_at),  SUPP ? 64'd257 : 64'd513);
        check_eq("rd_mdc",    64'(r.mdc_bad), 64'd0);
        check_eq("rd_stable", 64'(r.stab_bad), 64'd0);

        // Read with no PHY: pin idles high.
        run_frame(1'b0, 5'd1, 5'd1, 16'h0, 1'b0, 16'h0, 1'b0, r);
        check_eq("nophy_rdat", 64'(r.rdat), 64'hFFFF);
        check_eq("nophy_err",  64'(r.err),  64'd1);

        // Back-to-back with CMD_VALID held high across both commands.
        run_frame(1'b1, 5'd2, 5'd4, 16'hA5A5, 1'b0, 16'h0, 1'b1, r);
        check_eq("b2b1_bits",  r.obits, SUPP ? 64'h0000_0000_5112_A5A5 : 64'hFFFF_FFFF_5112_A5A5);
        check_eq("b2b1_ready", 64'(r.rdy_bad), 64'd0);
        check_eq("b2b1_n_vld", 64'(r.n_vld),   64'd1);
        check_eq("b2b1_rdat_hold", 64'(r.rdat), 64'hFFFF);
        check_eq("b2b1_err",   64'(r.err),     64'd0);
        run_frame(1'b0, 5'd3, 5'd31, 16'h0, 1'b1, 16'h0F0F, 1'b0, r);
        check_eq("b2b2_wait",  64'(r.wait_n),  64'd0);
        check_eq("b2b2_bits",  r.obits & (SUPP ? 64'h0000_0000_FFFC_0000 : 64'hFFFF_FFFF_FFFC_0000),
                               SUPP ? 64'h0000_0000_61FC_0000 : 64'hFFFF_FFFF_61FC_0000);
        check_eq("b2b2_n_vld", 64'(r.n_vld),   64'd1);
        check_eq("b2b2_rdat",  64'(r.rdat),    64'h0F0F);
        check_eq("b2b2_ready", 64'(r.rdy_bad), 64'd0);
        @(negedge clk);
        check_eq("b2b_pulse_end", 64'(rsp_valid), 64'd0);

        // Reset during bit 40 of a write (MDC high half of the bit).
        cmd_wr    = 1'b1;
        cmd_phyad = 5'd1;
        cmd_regad = 5'd0;
        cmd_wdat  = 16'h1140;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2 * 40 * DIV + DIV + 2) @(negedge clk);
        check_eq("abort_pre_mdc",   64'(mdc),   64'd1);
        check_eq("abort_pre_mdioe", 64'(mdioe), 64'd1);
        arstn = 1'b0;
        pre_armed = 1'b1;
        #1;
        check_eq("abort_mdc",   64'(mdc),   64'd0);
        check_eq("abort_mdioe", 64'(mdioe), 64'd0);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        nv = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1)
                nv++;
        end
        check_eq("abort_ready",  64'(cmd_ready), 64'd1);
        check_eq("abort_no_vld", 64'(nv),        64'd0);

        // Two reads after reset: the first is always full length.
        run_frame(1'b0, 5'd1, 5'd1, 16'h0, 1'b1, 16'h1234, 1'b0, r);
        check_eq("pair1_vld_at", 64'(r.vld_at), 64'd513);
        check_eq("pair1_rdat",   64'(r.rdat),   64'h1234);
        run_frame(1'b0, 5'd1, 5'd2, 16'h0, 1'b1, 16'hBEEF, 1'b0, r);
        check_eq("pair2_vld_at", 64'(r.vld_at), SUPP ? 64'd257 : 64'd513);
        check_eq("pair2_rdat",   64'(r.rdat),   64'hBEEF);
        check_eq("pair2_err",    64'(r.err),    64'd0);
        check_eq("pair2_bits",   r.obits & (SUPP ? 64'h0000_0000_FFFC_0000 : 64'hFFFF_FFFF_FFFC_0000),
                                 SUPP ? 64'h0000_0000_6088_0000 : 64'hFFFF_FFFF_6088_0000);
        check_eq("pair2_mdc",    64'(r.mdc_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
